receiver: RTL and testbench

Serial-line receiver for the team's single-wire 7-bit link: an idle-high line, a start bit, 7 data bits LSB first, then one even-parity bit, at one bit per `clk` cycle. It reconstructs each frame, checks parity, and presents the word to downstream logic over a valid/ready handshake. It sits at the far end of the link from the transmitter and runs on the same `clk`, so no oversampling or clock recovery is needed.

---
 rtl/serial_pkg.sv | 15 +
 rtl/receiver_if.sv | 15 +
 rtl/receiver.sv | 91 +++++++++
 tb/tb_receiver.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants and state encoding for the 7-bit serial link
package serial_pkg;

  localparam int DATA_BITS_DEFAULT = 7;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } rx_state_e;

endpackage

// File: rtl/receiver_if.sv
// rtl/receiver_if.sv - valid/ready word handshake between receiver and downstream logic
interface receiver_if
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
);

  logic [DATA_BITS-1:0] data_out;
  logic                 valid;
  logic                 ready;

  modport master (output data_out, output valid, input  ready);
  modport slave  (input  data_out, input  valid, output ready);

endinterface

// File: rtl/receiver.sv
// rtl/receiver.sv - frame receiver: start bit, DATA_BITS LSB-first data bits, even parity
module receiver
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          serial_in,
  receiver_if.master    bus,
  output logic          parity_err,
  output logic          overrun,
  output logic          busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ovr_q;
  logic                 busy_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
      // Consume first; a word completing on this same edge overrides it below.
      if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (serial_in == LINE_START) begin
            cnt_q   <= '0;
            state_q <= ST_DATA;
            busy_q  <= 1'b1;
          end
        end

        ST_DATA: begin
          shift_q[cnt_q] <= serial_in;
          if (cnt_q == LAST_BIT) begin
            state_q <= ST_PARITY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_PARITY: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if ((^shift_q) ^ serial_in) begin
            perr_q <= 1'b1;
          end else if (!valid_q || bus.ready) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign parity_err   = perr_q;
  assign overrun      = ovr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - directed table-driven bench for the serial receiver
module tb_receiver;

  logic clk;
  logic rstn;
  logic serial_in;
  logic parity_err;
  logic overrun;
  logic busy;

  int checks;
  int errors;

  receiver_if #(.DATA_BITS(7)) bus ();

  receiver #(.DATA_BITS(7)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .serial_in (serial_in),
    .bus       (bus.master),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] data;
    logic       par;
    logic       rdy;
    logic       exp_valid;
    logic [6:0] exp_data;
    logic       exp_perr;
    logic       exp_ovr;
    logic       exp_valid_idle;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic raise_ready_at_par);
    @(negedge clk) serial_in = 1'b0;
    @(posedge clk); #1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) serial_in = d[i];
      @(posedge clk);
    end
    @(negedge clk) serial_in = p;
    if (raise_ready_at_par) bus.ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_bit();
    @(negedge clk) serial_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string tag, input logic ev, input logic [6:0] ed,
                             input logic ep, input logic eo);
    check({tag, "_valid"}, {31'd0, bus.valid}, {31'd0, ev});
    check({tag, "_data"}, {25'd0, bus.data_out}, {25'd0, ed});
    check({tag, "_perr"}, {31'd0, parity_err}, {31'd0, ep});
    check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, eo});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //          data   par  rdy  ev    edata  perr ovr  ev_after_idle
    vecs[0] = '{7'h55, 1'b0, 1'b1, 1'b1, 7'h55, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{7'h07, 1'b1, 1'b1, 1'b1, 7'h07, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{7'h07, 1'b0, 1'b1, 1'b0, 7'h07, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{7'h12, 1'b0, 1'b1, 1'b1, 7'h12, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{7'h6D, 1'b1, 1'b1, 1'b1, 7'h6D, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{7'h7F, 1'b1, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{7'h11, 1'b0, 1'b0, 1'b1, 7'h11, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{7'h22, 1'b0, 1'b0, 1'b1, 7'h11, 1'b0, 1'b1, 1'b1};

    rstn      = 1'b0;
    serial_in = 1'b1;
    bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_frame("reset", 1'b0, 7'h00, 1'b0, 1'b0);
    @(negedge clk) rstn = 1'b1;
    idle_bit();

    for (int v = 0; v < 8; v++) begin
      bus.ready = vecs[v].rdy;
      send_frame(vecs[v].data, vecs[v].par, 1'b0);
      check_frame($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_data,
                  vecs[v].exp_perr, vecs[v].exp_ovr);
      idle_bit();
      check($sformatf("vec%0d_idle_valid", v), {31'd0, bus.valid}, {31'd0, vecs[v].exp_valid_idle});
      check($sformatf("vec%0d_idle_pulses", v), {30'd0, parity_err, overrun}, 32'd0);
    end

    // Backlog from the overrun rows drains once ready rises.
    @(negedge clk) bus.ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", {31'd0, bus.valid}, 32'd0);

    // Back-to-back frames, zero idle bits.
    send_frame(7'h12, 1'b0, 1'b0);
    check_frame("b2b0", 1'b1, 7'h12, 1'b0, 1'b0);
    send_frame(7'h6D, 1'b1, 1'b0);
    check_frame("b2b1", 1'b1, 7'h6D, 1'b0, 1'b0);
    send_frame(7'h7F, 1'b1, 1'b0);
    check_frame("b2b2", 1'b1, 7'h7F, 1'b0, 1'b0);
    idle_bit();
    check("b2b_idle_valid", {31'd0, bus.valid}, 32'd0);

    // Consume and load on the same edge.
    bus.ready = 1'b0;
    send_frame(7'h33, 1'b0, 1'b0);
    check_frame("same0", 1'b1, 7'h33, 1'b0, 1'b0);
    send_frame(7'h44, 1'b0, 1'b1);
    check_frame("same1", 1'b1, 7'h44, 1'b0, 1'b0);
    idle_bit();
    check("same_idle_valid", {31'd0, bus.valid}, 32'd0);

    // Reset mid-frame after data bit 3.
    @(negedge clk) serial_in = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) serial_in = 1'b1;
      @(posedge clk);
    end
    @(negedge clk) rstn = 1'b0;
    #1;
    check_frame("midrst", 1'b0, 7'h00, 1'b0, 1'b0);
    serial_in = 1'b1;
    @(negedge clk) rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle_bit();
      check($sformatf("midrst_quiet%0d", i), {28'd0, bus.valid, parity_err, overrun, busy}, 32'd0);
    end
    bus.ready = 1'b1;
    send_frame(7'h2A, 1'b1, 1'b0);
    check_frame("after_rst", 1'b1, 7'h2A, 1'b0, 1'b0);
    idle_bit();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
